// File: rtl/water_fill_arbiter.sv
// rtl/water_fill_arbiter.sv - round-robin single-inlet water fill arbiter with timeout and settle gap
// Optional FAULT_MASK_EN: faulted washers are excluded from arbitration until fault_clr.
module water_fill_arbiter #(
   parameter int N_WASHERS  = 4,
   parameter int FILL_MAX   = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_WASHERS-1:0] req,
   input  logic [N_WASHERS-1:0] done,
   input  logic [N_WASHERS-1:0] Door,
   input  logic [N_WASHERS-1:0] fault_clr,
   output logic [N_WASHERS-1:0] grant,
   output logic                 busy,
   output logic [N_WASHERS-1:0] fault
);

   localparam int PW = (N_WASHERS > 1) ? $clog2(N_WASHERS) : 1;
   // Counter also times the settle gap, so it must hold the larger of the two limits.
   localparam int CMAX = (GAP_CYCLES > FILL_MAX) ? GAP_CYCLES : FILL_MAX;
   localparam int CW = $clog2(CMAX + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_GRANT  = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;

   logic [1:0]           state;
   logic [CW-1:0]        cnt;
   logic [PW-1:0]        ptr;
   logic [PW-1:0]        gidx;
   logic [N_WASHERS-1:0] elig;
   logic                 found;
   logic [PW-1:0]        win;
   logic                 release_now;
   logic                 timeout;
   logic [PW-1:0]        ptr_next;
   logic [N_WASHERS-1:0] fault_set;

`ifdef FAULT_MASK_EN
   assign elig = req & ~Door & ~done & ~fault;
`else
   assign elig = req & ~Door & ~done;
`endif

   // Reverse scan so the final assignment is the first eligible index at or after ptr.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = N_WASHERS - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr) + k) % N_WASHERS;
         if (elig[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   always_comb begin
      release_now = Door[gidx] | done[gidx] | ~req[gidx] | (cnt == CW'(FILL_MAX));
      timeout     = (cnt == CW'(FILL_MAX)) & ~Door[gidx] & ~done[gidx] & req[gidx];
      ptr_next    = (int'(gidx) == N_WASHERS - 1) ? '0 : gidx + PW'(1);
      fault_set   = '0;
      if (state == S_GRANT && timeout)
         fault_set[gidx] = 1'b1;
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         ptr   <= '0;
         gidx  <= '0;
         grant <= '0;
         fault <= '0;
      end else begin
         fault <= (fault & ~fault_clr) | fault_set;
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant <= N_WASHERS'(1) << win;
                  gidx  <= win;
                  cnt   <= CW'(1);
                  state <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (release_now) begin
                  grant <= '0;
                  cnt   <= '0;
                  ptr   <= ptr_next;
                  state <= S_SETTLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_SETTLE: begin
               if (cnt == CW'(GAP_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               grant <= '0;
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_water_fill_arbiter.sv
// tb/tb_water_fill_arbiter.sv - randomized self-checking bench for water_fill_arbiter
// Reference model tracks owner / hold time / remaining gap directly from the arbitration rules.
module tb_water_fill_arbiter;

   localparam int N   = 4;
   localparam int FM  = 16;
   localparam int GAP = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req, done, Door, fault_clr;
   logic [N-1:0] grant, fault;
   logic         busy;

   always #5 clk = ~clk;

   water_fill_arbiter #(.N_WASHERS(N), .FILL_MAX(FM), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset(reset), .req(req), .done(done), .Door(Door),
      .fault_clr(fault_clr), .grant(grant), .busy(busy), .fault(fault)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model state: who holds the valve, for how long, how many gap cycles remain, where the scan starts.
   int           owner;
   int           held;
   int           gap_left;
   int           nxt;
   logic [N-1:0] mflt;
   int           timeouts_seen;

   task automatic model_reset();
      owner = -1; held = 0; gap_left = 0; nxt = 0; mflt = '0;
   endtask

   task automatic model_step();
      logic [N-1:0] el;
      logic [N-1:0] newf;
      int g;
      newf = mflt & ~fault_clr;
      if (owner >= 0) begin
         g = owner;
         if (Door[g] || done[g] || !req[g] || held == FM) begin
            if (!Door[g] && !done[g] && req[g]) begin
               newf[g] = 1'b1;
               timeouts_seen++;
            end
            owner = -1; gap_left = GAP; nxt = (g + 1) % N;
         end else begin
            held++;
         end
      end else if (gap_left > 0) begin
         gap_left--;
      end else begin
         el = req & ~Door & ~done;
`ifdef FAULT_MASK_EN
         el = el & ~mflt;
`endif
         for (int k = 0; k < N; k++) begin
            int w;
            w = (nxt + k) % N;
            if (el[w] && owner < 0) begin
               owner = w; held = 1;
            end
         end
      end
      mflt = newf;
   endtask

   task automatic compare(input string tag);
      logic [N-1:0] eg;
      eg = (owner >= 0) ? N'(1) << owner : '0;
      check({tag, ".grant"}, 32'(grant), 32'(eg));
      check({tag, ".busy"}, 32'(busy), 32'(owner >= 0 || gap_left > 0));
      check({tag, ".fault"}, 32'(fault), 32'(mflt));
      check({tag, ".onehot"}, 32'($countones(grant) <= 1), 32'd1);
   endtask

   // Called at a negedge with inputs already driven.
   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      compare(tag);
      @(negedge clk);
   endtask

   // mode 0: mixed events; mode 1: no done/Door/withdrawal so fills run to timeout.
   task automatic randomize_inputs(input int mode);
      for (int i = 0; i < N; i++) begin
         if (!req[i]) req[i] = ($urandom_range(3) == 0);
         else if (mode == 0 && $urandom_range(39) == 0) req[i] = 1'b0;
         done[i]      = (mode == 0) && ($urandom_range(9) == 0);
         Door[i]      = (mode == 0) && ($urandom_range(29) == 0);
         fault_clr[i] = ($urandom_range(24) == 0);
      end
   endtask

   initial begin
      timeouts_seen = 0;
      reset = 1'b1;
      req = '0; done = '0; Door = '0; fault_clr = '0;
      model_reset();
      #1;
      check("reset.grant", 32'(grant), 32'd0);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.fault", 32'(fault), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Directed single request: grant after one edge, done drops it, busy spans the gap.
      req = 4'b0001;
      cycle("single.rise");
      for (int c = 0; c < 3; c++) cycle("single.hold");
      done = 4'b0001;
      cycle("single.done");
      req = '0; done = '0;
      for (int c = 0; c < GAP + 2; c++) cycle("single.gap");

      for (int c = 0; c < 600; c++) begin
         randomize_inputs(0);
         cycle("rand_mix");
      end
      for (int c = 0; c < 300; c++) begin
         randomize_inputs(1);
         cycle("rand_timeout");
      end
      check("timeouts_exercised", 32'(timeouts_seen > 0), 32'd1);
      for (int c = 0; c < 300; c++) begin
         randomize_inputs(0);
         cycle("rand_mix2");
      end

      // Async reset mid-grant must drop grant and fault without waiting for an edge.
      req = 4'b0100; done = '0; Door = '0; fault_clr = '0;
      begin
         int budget;
         budget = 0;
         while ((owner < 0 || held < 3) && budget < 100) begin
            cycle("pre_reset");
            budget++;
         end
         check("pre_reset.granted", 32'(owner >= 0), 32'd1);
      end
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset.grant", 32'(grant), 32'd0);
      check("async_reset.busy", 32'(busy), 32'd0);
      check("async_reset.fault", 32'(fault), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      req = 4'b0001;
      cycle("post_reset.rise");
      check("post_reset.grant0", 32'(grant), 32'b0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
